fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end.
- Replaces the single-register PC plus IF/ID latch pair with a PC generator, a ROM interface of configurable read latency, and a DEPTH-entry prefetch queue feeding ID.
- Handles ctrl stalls, branch redirects from ID, and MIPS delay-slot retention, so ID sees the same pc/inst/valid stream as before without bubbles on sequential code.

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_queue.sv | 158 +++++++++++++++
 tb/tb_fetch_queue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int INST_ADDR_W   = 32;
  localparam int INST_W        = 32;
  localparam int FETCH_DEPTH   = 4;
  localparam int FETCH_ROM_LAT = 1;

  localparam logic [INST_W-1:0] NOP = '0;

  // How a taken branch in the head entry reshapes queue, in-flight line and PC.
  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_KEEP_QUEUE,
    REDIR_KEEP_SLOT,
    REDIR_REFETCH
  } redir_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, inst} pairs; pointers carry an extra MSB so
// full and empty are distinguishable.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int AW    = INST_ADDR_W,
  parameter int DW    = INST_W,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_pc,
  input  logic [DW-1:0]            push_inst,
  input  logic                     pop,
  input  logic                     flush_keep_second,
  output logic                     head_valid,
  output logic [AW-1:0]            head_pc,
  output logic [DW-1:0]            head_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
  localparam logic [PW:0] PTR_TWO = (PW+1)'(2);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];
  logic [PW:0]   rd_ptr, wr_ptr;

  assign count      = wr_ptr - rd_ptr;
  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr[PW-1:0]];
  assign head_inst  = inst_mem[rd_ptr[PW-1:0]];

  // Flushing keeps only the entry behind the head: it becomes the sole occupant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_keep_second) begin
      rd_ptr <= rd_ptr + PTR_ONE;
      wr_ptr <= rd_ptr + PTR_TWO;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are meaningful, and outputs are masked when the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush_keep_second) begin
      pc_mem[wr_ptr[PW-1:0]]   <= push_pc;
      inst_mem[wr_ptr[PW-1:0]] <= push_inst;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, fixed-latency ROM in-flight line,
// prefetch queue to ID, branch redirect with MIPS delay-slot retention.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                DATA_W   = INST_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter int                ROM_LAT  = FETCH_ROM_LAT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_W-1:0]      rom_addr_o,
  output logic                   rom_ce_o,
  input  logic [DATA_W-1:0]      rom_data_i,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [ADDR_W-1:0]      branch_target_i,
  output logic [ADDR_W-1:0]      id_pc_o,
  output logic [DATA_W-1:0]      id_inst_o,
  output logic                   id_valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0]     DEPTH_OCC = OW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  logic [ADDR_W-1:0]  fetch_pc, pending_target, ds_pc, oldest_pc;
  logic               pending_valid;
  logic [ADDR_W-1:0]  slot_pc [ROM_LAT];
  logic [ROM_LAT-1:0] slot_live, slot_keep, oldest_mask;
  logic [CW-1:0]      count;
  logic [OW-1:0]      live_cnt, occ_after;
  logic               head_valid, pop, issue, issue_live;
  logic [ADDR_W-1:0]  head_pc;
  logic [DATA_W-1:0]  head_inst;
  redir_e             redir;

  assign pop   = head_valid && !stall_i;
  assign ds_pc = head_pc + PC_STEP;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    live_cnt    = '0;
    oldest_mask = '0;
    oldest_pc   = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      live_cnt = live_cnt + OW'(slot_live[i]);
      if (slot_live[i]) begin
        oldest_mask    = '0;
        oldest_mask[i] = 1'b1;
        oldest_pc      = slot_pc[i];
      end
    end
  end

  // Space is reserved at issue time for every live slot, so returns never overflow.
  assign occ_after = OW'(count) + live_cnt - OW'(pop);
  assign issue     = rst && (occ_after < DEPTH_OCC);

  always_comb begin
    redir = REDIR_NONE;
    if (pop && branch_flag_i) begin
      if (count >= CW'(2))                                redir = REDIR_KEEP_QUEUE;
      else if ((|oldest_mask) && (oldest_pc == ds_pc))    redir = REDIR_KEEP_SLOT;
      else                                                redir = REDIR_REFETCH;
    end
  end

  always_comb begin
    slot_keep  = '0;
    issue_live = 1'b0;
    case (redir)
      REDIR_NONE: begin
        slot_keep  = slot_live;
        issue_live = issue;
      end
      REDIR_KEEP_SLOT: slot_keep = oldest_mask;
      REDIR_REFETCH:   issue_live = issue && (fetch_pc == ds_pc);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_live <= '0;
      for (int i = 0; i < ROM_LAT; i++) slot_pc[i] <= '0;
    end else begin
      slot_live[0] <= issue_live;
      slot_pc[0]   <= fetch_pc;
      for (int i = 1; i < ROM_LAT; i++) begin
        slot_live[i] <= slot_keep[i-1];
        slot_pc[i]   <= slot_pc[i-1];
      end
    end
  end

  // Refetch case: fetch the delay slot first, then resume at the parked target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc       <= RESET_PC;
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else begin
      case (redir)
        REDIR_KEEP_QUEUE, REDIR_KEEP_SLOT: begin
          fetch_pc      <= branch_target_i;
          pending_valid <= 1'b0;
        end
        REDIR_REFETCH: begin
          if (issue_live) begin
            fetch_pc      <= branch_target_i;
            pending_valid <= 1'b0;
          end else begin
            fetch_pc       <= ds_pc;
            pending_valid  <= 1'b1;
            pending_target <= branch_target_i;
          end
        end
        default: begin
          if (issue) begin
            if (pending_valid) begin
              fetch_pc      <= pending_target;
              pending_valid <= 1'b0;
            end else begin
              fetch_pc <= fetch_pc + PC_STEP;
            end
          end
        end
      endcase
    end
  end

  fetch_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk               (clk),
    .rst               (rst),
    .push              (slot_keep[ROM_LAT-1]),
    .push_pc           (slot_pc[ROM_LAT-1]),
    .push_inst         (rom_data_i),
    .pop               (pop),
    .flush_keep_second (redir == REDIR_KEEP_QUEUE),
    .head_valid        (head_valid),
    .head_pc           (head_pc),
    .head_inst         (head_inst),
    .count             (count)
  );

  assign rom_ce_o   = issue;
  assign rom_addr_o = issue ? fetch_pc : '0;
  assign id_valid_o = head_valid;
  assign id_pc_o    = head_valid ? head_pc : '0;
  assign id_inst_o  = head_valid ? head_inst : DATA_W'(NOP);
  assign count_o    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: two instances (ROM latency 1 and 3, the latter starting
// near the top of the address space) against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;

  logic [31:0] rom_addr_a, rom_data_a, id_pc_a, id_inst_a;
  logic [31:0] rom_addr_b, rom_data_b, id_pc_b, id_inst_b;
  logic        rom_ce_a, id_valid_a, rom_ce_b, id_valid_b;
  logic [2:0]  count_a, count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // ROM models: data for an address appears LAT cycles after it is presented.
  logic [31:0] radr [2][3];
  always @(posedge clk) begin
    radr[0][0] <= rom_addr_a;
    radr[1][0] <= rom_addr_b;
    for (int k = 0; k < 2; k++)
      for (int i = 1; i < 3; i++) radr[k][i] <= radr[k][i-1];
  end
  assign rom_data_a = rom_fn(radr[0][LAT_A-1]);
  assign rom_data_b = rom_fn(radr[1][LAT_B-1]);

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .ROM_LAT(LAT_A), .RESET_PC(RPC_A)) u_dut_a (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr_a), .rom_ce_o(rom_ce_a), .rom_data_i(rom_data_a),
    .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt), .id_pc_o(id_pc_a),
    .id_inst_o(id_inst_a), .id_valid_o(id_valid_a), .count_o(count_a));

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .ROM_LAT(LAT_B), .RESET_PC(RPC_B)) u_dut_b (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr_b), .rom_ce_o(rom_ce_b), .rom_data_i(rom_data_b),
    .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt), .id_pc_o(id_pc_b),
    .id_inst_o(id_inst_b), .id_valid_o(id_valid_b), .count_o(count_b));

  logic [31:0] d_pc [2], d_inst [2], d_addr [2];
  logic        d_valid [2], d_ce [2];
  logic [2:0]  d_cnt [2];
  assign d_pc[0] = id_pc_a;        assign d_pc[1] = id_pc_b;
  assign d_inst[0] = id_inst_a;    assign d_inst[1] = id_inst_b;
  assign d_addr[0] = rom_addr_a;   assign d_addr[1] = rom_addr_b;
  assign d_valid[0] = id_valid_a;  assign d_valid[1] = id_valid_b;
  assign d_ce[0] = rom_ce_a;       assign d_ce[1] = rom_ce_b;
  assign d_cnt[0] = count_a;       assign d_cnt[1] = count_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: ID queue as a head-first list, in-flight requests as an
  // age-ordered list (index LAT-1 is the one whose data is arriving).
  logic [31:0] m_q [2][DEPTH+1];
  int          m_cnt [2];
  logic [31:0] m_fpc [2][3];
  bit          m_flive [2][3];
  logic [31:0] m_fetch [2], m_pend [2];
  bit          m_pend_v [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int live_count(input int k);
    int n = 0;
    for (int i = 0; i < lat_of(k); i++) if (m_flive[k][i]) n++;
    return n;
  endfunction

  function automatic bit model_ce(input int k);
    int pop = (m_cnt[k] > 0 && !stall) ? 1 : 0;
    return rst && (m_cnt[k] + live_count(k) - pop < DEPTH);
  endfunction

  task automatic model_reset(input int k);
    m_cnt[k] = 0;
    for (int i = 0; i < 3; i++) m_flive[k][i] = 0;
    m_fetch[k]  = (k == 0) ? RPC_A : RPC_B;
    m_pend_v[k] = 0;
    m_pend[k]   = '0;
  endtask

  task automatic model_check(input int k);
    logic [31:0] epc, einst, eaddr;
    logic        ev, ece;
    int          ecnt;
    string       nm = (k == 0) ? "A" : "B";
    ev    = rst && (m_cnt[k] > 0);
    epc   = ev ? m_q[k][0] : '0;
    einst = ev ? rom_fn(epc) : '0;
    ecnt  = rst ? m_cnt[k] : 0;
    ece   = model_ce(k);
    eaddr = ece ? m_fetch[k] : '0;
    check({nm, " id_valid"}, 32'(d_valid[k]), 32'(ev));
    check({nm, " id_pc"},    d_pc[k],   epc);
    check({nm, " id_inst"},  d_inst[k], einst);
    check({nm, " count"},    32'(d_cnt[k]), 32'(ecnt));
    check({nm, " rom_ce"},   32'(d_ce[k]), 32'(ece));
    check({nm, " rom_addr"}, d_addr[k], eaddr);
  endtask

  task automatic model_advance(input int k);
    int          lat, oldest, mode;
    bit          ev, pop, ce, issue_keep, push;
    bit          keep [3];
    logic [31:0] ds, ret_pc;
    if (!rst) begin
      model_reset(k);
      return;
    end
    lat = lat_of(k);
    ev  = m_cnt[k] > 0;
    pop = ev && !stall;
    ce  = model_ce(k);
    ds  = m_q[k][0] + 32'd4;
    oldest = -1;
    for (int i = 0; i < lat; i++) if (m_flive[k][i]) oldest = i;
    mode = 0;  // 0 none, 1 keep queue entry, 2 keep in-flight slot, 3 refetch
    if (pop && br) begin
      if (m_cnt[k] >= 2) mode = 1;
      else if (oldest >= 0 && m_fpc[k][oldest] == ds) mode = 2;
      else mode = 3;
    end
    for (int i = 0; i < 3; i++)
      keep[i] = (i < lat) && m_flive[k][i] && (mode == 0 || (mode == 2 && i == oldest));
    issue_keep = ce && (mode == 0 || (mode == 3 && m_fetch[k] == ds));
    push   = keep[lat-1];
    ret_pc = m_fpc[k][lat-1];
    if (mode == 1) begin
      m_q[k][0] = m_q[k][1];
      m_cnt[k]  = 1;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH; i++) m_q[k][i] = m_q[k][i+1];
        m_cnt[k]--;
      end
      if (push && m_cnt[k] <= DEPTH) begin
        m_q[k][m_cnt[k]] = ret_pc;
        m_cnt[k]++;
      end
    end
    for (int i = lat - 1; i > 0; i--) begin
      m_fpc[k][i]   = m_fpc[k][i-1];
      m_flive[k][i] = keep[i-1];
    end
    m_fpc[k][0]   = m_fetch[k];
    m_flive[k][0] = issue_keep;
    if (mode == 1 || mode == 2 || (mode == 3 && issue_keep)) begin
      m_fetch[k]  = tgt;
      m_pend_v[k] = 0;
    end else if (mode == 3) begin
      m_fetch[k]  = ds;
      m_pend[k]   = tgt;
      m_pend_v[k] = 1;
    end else if (ce) begin
      if (m_pend_v[k]) begin
        m_fetch[k]  = m_pend[k];
        m_pend_v[k] = 0;
      end else begin
        m_fetch[k] = m_fetch[k] + 32'd4;
      end
    end
  endtask

  task automatic tick_begin();
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic tick_end();
    model_advance(0);
    model_advance(1);
    @(posedge clk);
    #1;
  endtask

  // Directed vectors for instance A (latency 1): sequential start, a 6-cycle
  // stall that fills the queue, then a branch at 0x10 to 0x100 with queue
  // {0x10,0x14,0x18}.
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        ce;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 32'h4};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   3'd1, 1'b1, 32'h8};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   3'd1, 1'b1, 32'hC};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3'd1, 1'b1, 32'h10};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3'd2, 1'b1, 32'h14};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3'd3, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3'd4, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3'd4, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   3'd4, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   3'd4, 1'b1, 32'h18};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   3'd3, 1'b1, 32'h1C};
    tbl[12] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h10,  3'd3, 1'b1, 32'h20};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  3'd1, 1'b1, 32'h100};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 32'h104};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 3'd1, 1'b1, 32'h108};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 3'd1, 1'b1, 32'h10C};

    model_reset(0);
    model_reset(1);
    repeat (2) begin
      tick_begin();
      tick_end();
    end
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].stall;
      br    = tbl[i].br;
      tgt   = tbl[i].tgt;
      tick_begin();
      check($sformatf("vec%0d valid", i), 32'(id_valid_a), 32'(tbl[i].valid));
      check($sformatf("vec%0d pc", i),    id_pc_a, tbl[i].pc);
      check($sformatf("vec%0d inst", i),  id_inst_a, tbl[i].valid ? rom_fn(tbl[i].pc) : 32'h0);
      check($sformatf("vec%0d count", i), 32'(count_a), 32'(tbl[i].cnt));
      check($sformatf("vec%0d ce", i),    32'(rom_ce_a), 32'(tbl[i].ce));
      check($sformatf("vec%0d addr", i),  rom_addr_a, tbl[i].addr);
      tick_end();
    end

    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 4) == 0);
      tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      tick_begin();
      tick_end();
    end

    // Reset pulse in the middle of a sequential burst with requests in flight.
    stall = 1'b0;
    br    = 1'b0;
    repeat (4) begin
      tick_begin();
      tick_end();
    end
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async rst %0d valid", k), 32'(d_valid[k]), 32'h0);
      check($sformatf("async rst %0d pc", k),    d_pc[k], 32'h0);
      check($sformatf("async rst %0d inst", k),  d_inst[k], 32'h0);
      check($sformatf("async rst %0d count", k), 32'(d_cnt[k]), 32'h0);
      check($sformatf("async rst %0d ce", k),    32'(d_ce[k]), 32'h0);
      check($sformatf("async rst %0d addr", k),  d_addr[k], 32'h0);
    end
    tick_begin();
    tick_end();
    rst = 1'b1;

    // Restart from the reset PCs; instance B walks across the 2^32 wrap.
    for (int c = 0; c < 9; c++) begin
      tick_begin();
      check($sformatf("restart B valid c%0d", c), 32'(id_valid_b), 32'(c >= LAT_B + 1));
      if (c >= LAT_B + 1)
        check($sformatf("wrap B pc c%0d", c), id_pc_b, RPC_B + 32'(4 * (c - LAT_B - 1)));
      if (c == LAT_A + 1)
        check("restart A first pc", id_pc_a, RPC_A);
      tick_end();
    end

    for (int i = 0; i < 200; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      br    = ($urandom_range(0, 3) == 0);
      tgt   = $urandom & 32'hFFFF_FFFC;
      tick_begin();
      tick_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
